// File: rtl/dual_ram_param_if.sv
// dual_ram_param_if: request/response bundle between a RAM user and dual_ram_param
interface dual_ram_param_if #(
  parameter int WIDTH = 8,
  parameter int ADDR = 4
);
  localparam int NBYTES = WIDTH / 8;
  logic write;
  logic [ADDR-1:0] wr_addr;
  logic [WIDTH-1:0] data_in;
  logic [NBYTES-1:0] wr_be;
  logic read;
  logic [ADDR-1:0] rd_addr;
  logic [WIDTH-1:0] data_out;
  logic rd_valid;
  logic busy;
  modport master (
    output write, wr_addr, data_in, wr_be, read, rd_addr,
    input data_out, rd_valid, busy
  );
  modport slave (
    input write, wr_addr, data_in, wr_be, read, rd_addr,
    output data_out, rd_valid, busy
  );
endinterface

// File: rtl/dual_ram_param.sv
// dual_ram_param: simple dual-port RAM with byte enables, 1/2-cycle read latency and post-reset clear
module dual_ram_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR = 4,
  parameter int RD_LAT = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic reset,
  dual_ram_param_if.slave bus
);
  localparam int NBYTES = WIDTH / 8;
  localparam logic [ADDR:0] LIM = (ADDR+1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST = ADDR'(DEPTH - 1);
  typedef enum logic {READY = 1'b0, CLEAR = 1'b1} state_t;
  state_t state, state_nx;
  logic [ADDR-1:0] clr_cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr_ok, rd_ok, p_v, fin_v;
  logic [WIDTH-1:0] rd_word, p_d, fin_d;
  always_ff @(posedge clk)
    state <= reset ? (CLEAR_ON_RESET != 0 ? CLEAR : READY) : state_nx;
  always_comb state_nx = (state == CLEAR && clr_cnt == LAST) ? READY : state;
  always_comb bus.busy = state == CLEAR;
  always_ff @(posedge clk)
    clr_cnt <= reset ? '0 : (state == CLEAR ? clr_cnt + 1'b1 : clr_cnt);
  assign wr_ok = !reset && state == READY && bus.write && {1'b0, bus.wr_addr} < LIM;
  assign rd_ok = !reset && state == READY && bus.read;
  // write-first forwards only the enabled bytes; out-of-range reads return zero
  always_comb begin
    rd_word = '0;
    if ({1'b0, bus.rd_addr} < LIM) begin
      rd_word = mem[bus.rd_addr];
      for (int i = 0; i < NBYTES; i++)
        if (COLLISION_MODE == 1 && wr_ok && bus.wr_addr == bus.rd_addr && bus.wr_be[i])
          rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR)
      mem[clr_cnt] <= '0;
    else if (wr_ok)
      for (int i = 0; i < NBYTES; i++)
        if (bus.wr_be[i]) mem[bus.wr_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
  end
  assign fin_v = RD_LAT == 2 ? p_v : rd_ok;
  assign fin_d = RD_LAT == 2 ? p_d : rd_word;
  always_ff @(posedge clk) begin
    if (reset) begin
      p_v <= 1'b0;
      p_d <= '0;
      bus.rd_valid <= 1'b0;
      bus.data_out <= '0;
    end else begin
      p_v <= rd_ok;
      if (rd_ok) p_d <= rd_word;
      bus.rd_valid <= fin_v;
      if (fin_v) bus.data_out <= fin_d;
    end
  end
endmodule

// File: tb/tb_dual_ram_param.sv
// tb_dual_ram_param: three RAM variants driven in lockstep, checked against a transaction scoreboard
module tb_dual_ram_param;
  typedef struct {int due; logic [15:0] d;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  dual_ram_param_if #(.WIDTH(16), .ADDR(4)) b0 ();
  dual_ram_param_if #(.WIDTH(16), .ADDR(4)) b1 ();
  dual_ram_param_if #(.WIDTH(16), .ADDR(4)) b2 ();
  dual_ram_param #(.WIDTH(16), .DEPTH(16), .ADDR(4), .RD_LAT(1), .COLLISION_MODE(0), .CLEAR_ON_RESET(1))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  dual_ram_param #(.WIDTH(16), .DEPTH(16), .ADDR(4), .RD_LAT(2), .COLLISION_MODE(1), .CLEAR_ON_RESET(1))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  dual_ram_param #(.WIDTH(16), .DEPTH(12), .ADDR(4), .RD_LAT(1), .COLLISION_MODE(0), .CLEAR_ON_RESET(1))
    u2 (.clk(clk), .reset(reset), .bus(b2));
  int lat [3] = '{1, 2, 1};
  int mode [3] = '{0, 1, 0};
  int dep [3] = '{16, 16, 12};
  logic [15:0] mem [3][16];
  ent_t q [3][$];
  int clr_left [3] = '{0, 0, 0};
  logic [15:0] last [3] = '{16'h0, 16'h0, 16'h0};
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic vv [3], bb [3];
  logic [15:0] dd [3];
  always_comb begin
    vv = '{b0.rd_valid, b1.rd_valid, b2.rd_valid};
    bb = '{b0.busy, b1.busy, b2.busy};
    dd = '{b0.data_out, b1.data_out, b2.data_out};
  end
  task automatic step(input string tag, input logic rst, input logic w, input logic [3:0] wa,
                      input logic [15:0] d, input logic [1:0] be, input logic r, input logic [3:0] ra);
    ent_t e;
    logic ev;
    reset = rst;
    b0.write = w; b0.wr_addr = wa; b0.data_in = d; b0.wr_be = be; b0.read = r; b0.rd_addr = ra;
    b1.write = w; b1.wr_addr = wa; b1.data_in = d; b1.wr_be = be; b1.read = r; b1.rd_addr = ra;
    b2.write = w; b2.wr_addr = wa; b2.data_in = d; b2.wr_be = be; b2.read = r; b2.rd_addr = ra;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        clr_left[k] = dep[k];
        q[k].delete();
        last[k] = '0;
        for (int a = 0; a < 16; a++) mem[k][a] = '0;
      end else if (clr_left[k] > 0) begin
        clr_left[k]--;
      end else begin
        if (r) begin
          e.d = int'(ra) < dep[k] ? mem[k][ra] : 16'h0;
          if (mode[k] == 1 && w && wa == ra && int'(ra) < dep[k])
            for (int b = 0; b < 2; b++) if (be[b]) e.d[8*b +: 8] = d[8*b +: 8];
          e.due = cyc + lat[k] - 1;
          q[k].push_back(e);
        end
        if (w && int'(wa) < dep[k])
          for (int b = 0; b < 2; b++) if (be[b]) mem[k][wa][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      ev = q[k].size() > 0 && q[k][0].due == cyc;
      if (ev) begin
        last[k] = q[k][0].d;
        void'(q[k].pop_front());
      end
      n_cmp++;
      assert (vv[k] === ev) else begin
        n_err++;
        $error("FAIL %s dut%0d rd_valid got %b exp %b", tag, k, vv[k], ev);
      end
      n_cmp++;
      assert (dd[k] === last[k]) else begin
        n_err++;
        $error("FAIL %s dut%0d data_out got %h exp %h", tag, k, dd[k], last[k]);
      end
      n_cmp++;
      assert (bb[k] === (clr_left[k] > 0)) else begin
        n_err++;
        $error("FAIL %s dut%0d busy got %b exp %b", tag, k, bb[k], clr_left[k] > 0);
      end
    end
  endtask
  initial begin
    step("rst", 1, 0, 0, 0, 0, 0, 0);
    step("rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step("busy_rd", 0, 1, 4'(i), 16'hFFFF, 2'b11, 1, 4'(i));
    for (int i = 0; i < 16; i++) step("clr_rd", 0, 0, 0, 0, 0, 1, 4'(i));
    step("be_w11", 0, 1, 3, 16'hABCD, 2'b11, 0, 0);
    step("be_w01", 0, 1, 3, 16'h1234, 2'b01, 0, 0);
    step("be_w00", 0, 1, 3, 16'hFFFF, 2'b00, 0, 0);
    step("be_rd", 0, 0, 0, 0, 0, 1, 3);
    step("be_idle", 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("lat_w", 0, 1, 4'(i), 16'($urandom), 2'b11, 0, 0);
    for (int i = 0; i < 10; i++) step("lat_rd", 0, 0, 0, 0, 0, 1, 4'(i));
    for (int i = 0; i < 3; i++) step("lat_idle", 0, 0, 0, 0, 0, 0, 0);
    step("col_w", 0, 1, 5, 16'h0011, 2'b11, 0, 0);
    step("col_wr", 0, 1, 5, 16'h0022, 2'b11, 1, 5);
    step("col_rd", 0, 0, 0, 0, 0, 1, 5);
    step("col_be", 0, 1, 5, 16'hAA33, 2'b01, 1, 5);
    step("col_rd2", 0, 0, 0, 0, 0, 1, 5);
    step("col_idle", 0, 0, 0, 0, 0, 0, 0);
    step("oor_w", 0, 1, 13, 16'h00FF, 2'b11, 0, 0);
    step("oor_rd", 0, 0, 0, 0, 0, 1, 13);
    for (int i = 0; i < 16; i++) step("oor_scan", 0, 0, 0, 0, 0, 1, 4'(i));
    step("diff_wr", 0, 1, 7, 16'h5A5A, 2'b11, 1, 8);
    step("diff_rd", 0, 0, 0, 0, 0, 1, 7);
    step("mid_rd", 0, 0, 0, 0, 0, 1, 5);
    step("mid_rst", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step("mid_clr", 0, 1, 5, 16'hBEEF, 2'b11, 1, 5);
    step("mid_after", 0, 0, 0, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) step("tail", 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
